// File: rtl/scr1_wb_pkg.sv
// Shared types and sizing for the write-back arbiter and its write buffer.
package scr1_wb_pkg;

  localparam int unsigned SCR1_WB_XLEN = 32;
  localparam int unsigned SCR1_WB_AW   = 5;

  localparam int unsigned SCR1_WBUF_DEPTH_DFLT = 2;
  localparam int unsigned SCR1_WBUF_PTR_W      = $clog2(SCR1_WBUF_DEPTH_DFLT);

  typedef struct packed {
    logic                    vld;
    logic [SCR1_WB_AW-1:0]   addr;
    logic [SCR1_WB_XLEN-1:0] data;
  } type_scr1_wb_entry_s;

endpackage

// File: rtl/scr1_pipe_wbuf.sv
// EXU write-buffer FIFO: enqueue/dequeue, address-match kill, and a
// two-port youngest-match lookup. Killed entries are skipped at the head.
module scr1_pipe_wbuf
    import scr1_wb_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = SCR1_WBUF_DEPTH_DFLT,
    parameter int unsigned XLEN       = SCR1_WB_XLEN,
    parameter int unsigned AW         = SCR1_WB_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_enq,
    input  logic [AW-1:0]   i_enq_addr,
    input  logic [XLEN-1:0] i_enq_data,
    input  logic            i_deq,
    input  logic            i_kill,
    input  logic [AW-1:0]   i_kill_addr,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    output logic            o_full,
    output logic            o_head_vld,
    output logic [AW-1:0]   o_head_addr,
    output logic [XLEN-1:0] o_head_data,
    output logic            o_rs1_hit,
    output logic [XLEN-1:0] o_rs1_data,
    output logic            o_rs2_hit,
    output logic [XLEN-1:0] o_rs2_data
);

    localparam int unsigned PTR_W = (WBUF_DEPTH == SCR1_WBUF_DEPTH_DFLT) ? SCR1_WBUF_PTR_W
                                                                        : $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    type_scr1_wb_entry_s r_mem [WBUF_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [CNT_W-1:0]    r_cnt;

    logic [PTR_W-1:0]    w_head_idx;
    logic [PTR_W-1:0]    w_head_scan;
    logic [CNT_W-1:0]    w_head_off;
    logic [CNT_W-1:0]    w_pop;
    logic [PTR_W-1:0]    w_lkp_scan;

    // First live entry from the head; dead entries ahead of it are popped for free.
    always_comb begin
        o_head_vld  = 1'b0;
        w_head_off  = '0;
        w_head_idx  = r_rd_ptr;
        w_head_scan = r_rd_ptr;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            w_head_scan = r_rd_ptr + PTR_W'(i);
            if (!o_head_vld && (CNT_W'(i) < r_cnt) && r_mem[w_head_scan].vld) begin
                o_head_vld = 1'b1;
                w_head_off = CNT_W'(i);
                w_head_idx = w_head_scan;
            end
        end
        w_pop = o_head_vld ? (w_head_off + CNT_W'(i_deq)) : r_cnt;
    end

    assign o_head_addr = r_mem[w_head_idx].addr;
    assign o_head_data = r_mem[w_head_idx].data;
    assign o_full      = (r_cnt == CNT_W'(WBUF_DEPTH));

    // Scan oldest to youngest so the last match is the youngest one.
    always_comb begin
        o_rs1_hit  = 1'b0;
        o_rs1_data = '0;
        o_rs2_hit  = 1'b0;
        o_rs2_data = '0;
        w_lkp_scan = r_rd_ptr;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            w_lkp_scan = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_cnt) && r_mem[w_lkp_scan].vld) begin
                if (r_mem[w_lkp_scan].addr == i_rs1_addr) begin
                    o_rs1_hit  = 1'b1;
                    o_rs1_data = r_mem[w_lkp_scan].data;
                end
                if (r_mem[w_lkp_scan].addr == i_rs2_addr) begin
                    o_rs2_hit  = 1'b1;
                    o_rs2_data = r_mem[w_lkp_scan].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
                if (i_kill && r_mem[i].vld && (r_mem[i].addr == i_kill_addr)) begin
                    r_mem[i].vld <= 1'b0;
                end
            end
            if (i_enq) begin
                r_mem[r_wr_ptr].vld  <= !(i_kill && (i_enq_addr == i_kill_addr));
                r_mem[r_wr_ptr].addr <= i_enq_addr;
                r_mem[r_wr_ptr].data <= i_enq_data;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_enq);
            r_rd_ptr <= r_rd_ptr + w_pop[PTR_W-1:0];
            r_cnt    <= r_cnt - w_pop + CNT_W'(i_enq);
        end
    end

endmodule

// File: rtl/scr1_pipe_wb_arb.sv
// Write-back arbiter in front of the MPRF write port: LSU > buffered EXU > direct EXU,
// load scoreboard, and read-path forwarding (SCR1_WB_FWD_EN) or hazard-only mode.
module scr1_pipe_wb_arb
    import scr1_wb_pkg::*;
#(
    parameter int unsigned WBUF_DEPTH = SCR1_WBUF_DEPTH_DFLT,
    parameter int unsigned XLEN       = SCR1_WB_XLEN,
    parameter int unsigned AW         = SCR1_WB_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exu_wb_req,
    output logic            exu_wb_rdy,
    input  logic [AW-1:0]   exu_wb_addr,
    input  logic [XLEN-1:0] exu_wb_data,
    input  logic            lsu_ld_issue,
    input  logic [AW-1:0]   lsu_ld_rd_addr,
    input  logic            lsu_wb_req,
    input  logic [AW-1:0]   lsu_wb_addr,
    input  logic [XLEN-1:0] lsu_wb_data,
    input  logic [AW-1:0]   exu_rs1_addr,
    input  logic [AW-1:0]   exu_rs2_addr,
    input  logic [XLEN-1:0] mprf_rs1_data,
    input  logic [XLEN-1:0] mprf_rs2_data,
    output logic [XLEN-1:0] exu_rs1_data,
    output logic [XLEN-1:0] exu_rs2_data,
    output logic            exu_rs1_hazard,
    output logic            exu_rs2_hazard,
    output logic            mprf_w_req,
    output logic [AW-1:0]   mprf_rd_addr,
    output logic [XLEN-1:0] mprf_rd_data
);

    localparam int unsigned NREG = 2 ** AW;

    type_scr1_wb_entry_s r_out;
    type_scr1_wb_entry_s w_out_nxt;
    logic [NREG-1:0]     r_pending;
    logic [NREG-1:0]     w_pending_nxt;

    logic            w_exu_xfer;
    logic            w_exu_sel;
    logic            w_enq;
    logic            w_deq;
    logic            w_full;
    logic            w_head_vld;
    logic [AW-1:0]   w_head_addr;
    logic [XLEN-1:0] w_head_data;
    logic            w_rs1_hit;
    logic            w_rs2_hit;
    logic [XLEN-1:0] w_rs1_buf;
    logic [XLEN-1:0] w_rs2_buf;
    logic            w_rs1_out_hit;
    logic            w_rs2_out_hit;
    logic            w_rs1_pend;
    logic            w_rs2_pend;

    assign exu_wb_rdy = !w_full;
    assign w_exu_xfer = exu_wb_req && exu_wb_rdy;

    always_comb begin
        w_out_nxt = '0;
        w_deq     = 1'b0;
        w_exu_sel = 1'b0;
        if (lsu_wb_req && (lsu_wb_addr != '0)) begin
            w_out_nxt.vld  = 1'b1;
            w_out_nxt.addr = lsu_wb_addr;
            w_out_nxt.data = lsu_wb_data;
        end else if (w_head_vld) begin
            w_out_nxt.vld  = 1'b1;
            w_out_nxt.addr = w_head_addr;
            w_out_nxt.data = w_head_data;
            w_deq          = 1'b1;
        end else if (w_exu_xfer && (exu_wb_addr != '0)) begin
            w_out_nxt.vld  = 1'b1;
            w_out_nxt.addr = exu_wb_addr;
            w_out_nxt.data = exu_wb_data;
            w_exu_sel      = 1'b1;
        end
        w_enq = w_exu_xfer && (exu_wb_addr != '0) && !w_exu_sel;
    end

    scr1_pipe_wbuf #(
        .WBUF_DEPTH (WBUF_DEPTH),
        .XLEN       (XLEN),
        .AW         (AW)
    ) i_wbuf (
        .clk         (clk),
        .rst         (rst),
        .i_enq       (w_enq),
        .i_enq_addr  (exu_wb_addr),
        .i_enq_data  (exu_wb_data),
        .i_deq       (w_deq),
        .i_kill      (lsu_wb_req),
        .i_kill_addr (lsu_wb_addr),
        .i_rs1_addr  (exu_rs1_addr),
        .i_rs2_addr  (exu_rs2_addr),
        .o_full      (w_full),
        .o_head_vld  (w_head_vld),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_rs1_hit   (w_rs1_hit),
        .o_rs1_data  (w_rs1_buf),
        .o_rs2_hit   (w_rs2_hit),
        .o_rs2_data  (w_rs2_buf)
    );

    // Set wins over clear when a load issues to the address returning this cycle.
    always_comb begin
        w_pending_nxt = r_pending;
        if (lsu_wb_req) begin
            w_pending_nxt[lsu_wb_addr] = 1'b0;
        end
        if (lsu_ld_issue && (lsu_ld_rd_addr != '0)) begin
            w_pending_nxt[lsu_ld_rd_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out     <= '0;
            r_pending <= '0;
        end else begin
            r_out     <= w_out_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign mprf_w_req   = r_out.vld;
    assign mprf_rd_addr = r_out.addr;
    assign mprf_rd_data = r_out.data;

    assign w_rs1_pend    = (exu_rs1_addr != '0) && r_pending[exu_rs1_addr];
    assign w_rs2_pend    = (exu_rs2_addr != '0) && r_pending[exu_rs2_addr];
    assign w_rs1_out_hit = r_out.vld && (r_out.addr == exu_rs1_addr);
    assign w_rs2_out_hit = r_out.vld && (r_out.addr == exu_rs2_addr);

`ifdef SCR1_WB_FWD_EN
    always_comb begin
        exu_rs1_hazard = w_rs1_pend;
        exu_rs2_hazard = w_rs2_pend;
        if (exu_rs1_addr == '0)  exu_rs1_data = '0;
        else if (w_rs1_hit)      exu_rs1_data = w_rs1_buf;
        else if (w_rs1_out_hit)  exu_rs1_data = r_out.data;
        else                     exu_rs1_data = mprf_rs1_data;
        if (exu_rs2_addr == '0)  exu_rs2_data = '0;
        else if (w_rs2_hit)      exu_rs2_data = w_rs2_buf;
        else if (w_rs2_out_hit)  exu_rs2_data = r_out.data;
        else                     exu_rs2_data = mprf_rs2_data;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd   = ^{w_rs1_buf, w_rs2_buf};
    assign exu_rs1_data   = mprf_rs1_data;
    assign exu_rs2_data   = mprf_rs2_data;
    assign exu_rs1_hazard = (exu_rs1_addr != '0) && (w_rs1_pend || w_rs1_hit || w_rs1_out_hit);
    assign exu_rs2_hazard = (exu_rs2_addr != '0) && (w_rs2_pend || w_rs2_hit || w_rs2_out_hit);
`endif

`ifdef SCR1_SIM_ENV
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(lsu_ld_issue && (lsu_ld_rd_addr != '0) && r_pending[lsu_ld_rd_addr]
                      && !(lsu_wb_req && (lsu_wb_addr == lsu_ld_rd_addr))))
                else $error("load issued to an already pending rd");
            assert (!(lsu_wb_req && (lsu_wb_addr != '0) && !r_pending[lsu_wb_addr]))
                else $error("load return to a non-pending rd");
            assert (!(mprf_w_req && $isunknown({mprf_rd_addr, mprf_rd_data})))
                else $error("unknown value on MPRF write port");
        end
    end
`endif

endmodule
